// File: rtl/aes_defs.sv
// ---------------------------------------------------------------------------
// aes_defs : shared AES definitions.
//   - State/column geometry (AES-128 state is 4 columns of 32 bits).
//   - FSM encoding for the column-serial round back end.
//   - shiftrows(): byte-permutation helper, also reused by other AES tops.
// Byte order everywhere: byte k = state[127-8k -: 8], row = k%4, col = k/4.
// ---------------------------------------------------------------------------
package aes_defs;

  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;
  localparam int AES_NCOL    = 4;

  // Column view of the state: index 0 is the MSB word, i.e. column 0.
  typedef logic [0:AES_NCOL-1][AES_COL_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MIX  = 2'd1,
    ST_DONE = 2'd2
  } aes_st_e;

  // s'(r,c) = s(r,(c+r) mod 4)
  function automatic logic [AES_STATE_W-1:0] shiftrows(input logic [AES_STATE_W-1:0] s);
    logic [AES_STATE_W-1:0] o;
    o = '0;
    for (int c = 0; c < AES_NCOL; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[AES_STATE_W-1-8*(4*c+r) -: 8] = s[AES_STATE_W-1-8*(4*((c+r)%4)+r) -: 8];
      end
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_mixcolumn.sv
// ---------------------------------------------------------------------------
// aes_mixcolumn : combinational AES MixColumns on a single 32-bit column.
//   i_col  in  32  column, row 0 in bits [31:24]
//   o_col  out 32  mixed column, same byte order
// GF(2^8) multiply-by-2 is xtime with the 0x1b reduction polynomial;
// multiply-by-3 is xtime(a) ^ a.
// ---------------------------------------------------------------------------
module aes_mixcolumn
  import aes_defs::*;
(
  input  logic [AES_COL_W-1:0] i_col,
  output logic [AES_COL_W-1:0] o_col
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0] w_x0, w_x1, w_x2, w_x3;

  assign w_a0 = i_col[31:24];
  assign w_a1 = i_col[23:16];
  assign w_a2 = i_col[15:8];
  assign w_a3 = i_col[7:0];

  assign w_x0 = xtime(w_a0);
  assign w_x1 = xtime(w_a1);
  assign w_x2 = xtime(w_a2);
  assign w_x3 = xtime(w_a3);

  // Row i: 2*a[i] ^ 3*a[i+1] ^ a[i+2] ^ a[i+3]
  assign o_col[31:24] = w_x0 ^ (w_x1 ^ w_a1) ^ w_a2 ^ w_a3;
  assign o_col[23:16] = w_a0 ^ w_x1 ^ (w_x2 ^ w_a2) ^ w_a3;
  assign o_col[15:8]  = w_a0 ^ w_a1 ^ w_x2 ^ (w_x3 ^ w_a3);
  assign o_col[7:0]   = (w_x0 ^ w_a0) ^ w_a1 ^ w_a2 ^ w_x3;

endmodule

// File: rtl/aes_round_mix.sv
// ---------------------------------------------------------------------------
// aes_round_mix : column-serial AES round back end
//                 ShiftRows -> MixColumns -> AddRoundKey.
//   clk        in   1    clock, rising edge
//   rst        in   1    async active-high reset
//   in_valid   in   1    upstream state/key valid
//   in_ready   out  1    high only in IDLE
//   in_state   in   128  post-SubBytes state
//   in_key     in   128  round key
//   in_last    in   1    final round: bypass MixColumns
//   out_valid  out  1    result valid, held until out_ready
//   out_ready  in   1    downstream accept
//   out_state  out  128  round result
// ShiftRows is applied as the state is captured; one shared mixcolumn
// instance then processes one column per cycle, written back in place.
// A state occupies the block for 1 IDLE + 4 MIX + 1 DONE cycles, so with
// out_ready tied high in_ready is low for 5 cycles between acceptances.
// ---------------------------------------------------------------------------
module aes_round_mix
  import aes_defs::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic [AES_STATE_W-1:0] in_key,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state
);

  aes_st_e          r_st, w_st_nxt;
  logic [1:0]       r_col_cnt;
  aes_state_t       r_work;
  aes_state_t       r_key;
  logic             r_last;

  logic [AES_COL_W-1:0] w_col, w_key_col, w_mixed, w_col_new;

  // Column mux feeding the shared mixcolumn unit.
  assign w_col     = r_work[r_col_cnt];
  assign w_key_col = r_key[r_col_cnt];

  aes_mixcolumn u_mix (
    .i_col (w_col),
    .o_col (w_mixed)
  );

  assign w_col_new = (r_last ? w_col : w_mixed) ^ w_key_col;

  // Handshake outputs decode the state register only: no comb path from
  // out_ready to in_ready.
  assign in_ready  = (r_st == ST_IDLE);
  assign out_valid = (r_st == ST_DONE);
  assign out_state = r_work;

  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_IDLE: if (in_valid)                        w_st_nxt = ST_MIX;
      ST_MIX:  if (r_col_cnt == 2'(AES_NCOL - 1))   w_st_nxt = ST_DONE;
      ST_DONE: if (out_ready)                       w_st_nxt = ST_IDLE;
      default:                                      w_st_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_st <= ST_IDLE;
    else     r_st <= w_st_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_col_cnt <= '0;
      r_work    <= '0;
      r_key     <= '0;
      r_last    <= 1'b0;
    end else begin
      case (r_st)
        ST_IDLE: if (in_valid) begin
          r_work    <= aes_state_t'(shiftrows(in_state));
          r_key     <= aes_state_t'(in_key);
          r_last    <= in_last;
          r_col_cnt <= '0;
        end
        ST_MIX: begin
          // Write-back demux; counter wraps 3 -> 0 on entry to DONE.
          r_work[r_col_cnt] <= w_col_new;
          r_col_cnt         <= r_col_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_mix.sv
module tb_aes_round_mix;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_last, out_valid, out_ready;
  logic [127:0] in_state, in_key, out_state;

  int errors = 0;
  int checks = 0;

  localparam logic [127:0] R1_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] R1_KEY  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R1_OUT  = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] FIN_OUT = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  // Bytes placed so that ShiftRows lands db,13,53,45 in column 0.
  localparam logic [127:0] SC_IN   = 128'hdb000000_00130000_00005300_00000045;
  localparam logic [127:0] SC_OUT  = 128'h8e4da1bc_00000000_00000000_00000000;

  aes_round_mix dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .in_key    (in_key),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  // One full transaction: transfer, count edges to out_valid, accept.
  task automatic send(input logic [127:0] s, input logic [127:0] k, input logic l,
                      output logic [127:0] res, output int lat, output bit tmo);
    int n;
    n = 0; tmo = 1'b0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    in_state = s; in_key = k; in_last = l; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!out_valid) tmo = 1'b1;
    res = out_state;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_state !== 128'h0) begin errors++; $display("FAIL reset_out_state got=%h exp=0", out_state); end
  endtask

  task automatic test_round1;
    logic [127:0] r; int lat; bit tmo;
    send(R1_IN, R1_KEY, 1'b0, r, lat, tmo);
    checks++; if (tmo) begin errors++; $display("FAIL round1_timeout got=timeout exp=out_valid"); end
    checks++; if (r !== R1_OUT) begin errors++; $display("FAIL round1_state got=%h exp=%h", r, R1_OUT); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL round1_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_final;
    logic [127:0] r; int lat; bit tmo;
    send(R1_IN, 128'h0, 1'b1, r, lat, tmo);
    checks++; if (r !== FIN_OUT) begin errors++; $display("FAIL final_state got=%h exp=%h", r, FIN_OUT); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL final_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_single_col;
    logic [127:0] r; int lat; bit tmo;
    send(SC_IN, 128'h0, 1'b0, r, lat, tmo);
    checks++; if (r !== SC_OUT) begin errors++; $display("FAIL single_col got=%h exp=%h", r, SC_OUT); end
  endtask

  task automatic test_backpressure;
    int n;
    in_state = R1_IN; in_key = R1_KEY; in_last = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    checks++; if (!out_valid) begin errors++; $display("FAIL bp_timeout got=no out_valid exp=out_valid"); end
    for (int i = 0; i < 10; i++) begin
      // Busy-time in_valid pulses with different data must be ignored.
      in_valid = i[0]; in_state = SC_IN; in_key = 128'hffff; in_last = 1'b1;
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d] got=%b exp=1", i, out_valid); end
      checks++; if (out_state !== R1_OUT) begin errors++; $display("FAIL bp_out_state[%0d] got=%h exp=%h", i, out_state, R1_OUT); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got=%b exp=0", i, in_ready); end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_hold got=%b exp=1", in_ready); end
  endtask

  task automatic test_back_to_back;
    logic [127:0] vs[3], vk[3], vo[3];
    logic         vl[3];
    int idx, nout, low;
    vs = '{R1_IN, R1_IN, SC_IN}; vk = '{R1_KEY, 128'h0, 128'h0};
    vl = '{1'b0, 1'b1, 1'b0};   vo = '{R1_OUT, FIN_OUT, SC_OUT};
    idx = 0; nout = 0; low = 0;
    out_ready = 1'b1;
    in_state = vs[0]; in_key = vk[0]; in_last = vl[0]; in_valid = 1'b1;
    for (int cyc = 0; cyc < 60 && nout < 3; cyc++) begin
      if (out_valid) begin
        checks++;
        if (out_state !== vo[nout]) begin errors++; $display("FAIL b2b_state[%0d] got=%h exp=%h", nout, out_state, vo[nout]); end
        nout++;
      end
      if (in_ready && idx < 3) begin
        if (idx > 0) begin
          checks++;
          if (low !== 5) begin errors++; $display("FAIL b2b_gap[%0d] got=%0d exp=5", idx, low); end
        end
        low = 0; idx++;
      end else if (!in_ready) low++;
      @(posedge clk); #1;
      if (idx < 3) begin in_state = vs[idx]; in_key = vk[idx]; in_last = vl[idx]; end
      else in_valid = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (nout !== 3) begin errors++; $display("FAIL b2b_count got=%0d exp=3", nout); end
  endtask

  task automatic test_reset_mid;
    logic [127:0] r; int lat; bit tmo;
    in_state = R1_IN; in_key = R1_KEY; in_last = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;   // now in MIX cycle 2
    #2 rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_state !== 128'h0) begin errors++; $display("FAIL rstmid_out_state got=%h exp=0", out_state); end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_no_output[%0d] got=%b exp=0", i, out_valid); end
    end
    send(SC_IN, 128'h0, 1'b0, r, lat, tmo);
    checks++; if (r !== SC_OUT) begin errors++; $display("FAIL rstmid_next got=%h exp=%h", r, SC_OUT); end
    checks++; if (lat !== 4) begin errors++; $display("FAIL rstmid_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_last = 1'b0;
    in_state = '0; in_key = '0;
    #12;
    test_reset;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    test_round1;
    test_final;
    test_single_col;
    test_backpressure;
    test_back_to_back;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
